idct4_row_engine: RTL and testbench



---
 rtl/idct4_row_engine_if.sv | 30 +++
 rtl/idct4_row_engine.sv | 140 ++++++++++++++
 tb/tb_idct4_row_engine.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/idct4_row_engine_if.sv
// Handshake/bus bundle for idct4_row_engine.
//   Input side : in_valid/in_ready with coefficient vector d_in_1..d_in_4 (x0..x3).
//   Output side: out_valid/out_ready with d_out (y[out_idx]), out_idx and out_last.
// slave  = engine view, master = producer/consumer view.
interface idct4_row_engine_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 24
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  d_in_1;
  logic signed [IN_W-1:0]  d_in_2;
  logic signed [IN_W-1:0]  d_in_3;
  logic signed [IN_W-1:0]  d_in_4;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] d_out;
  logic [1:0]              out_idx;
  logic                    out_last;

  modport slave (
    input  in_valid, d_in_1, d_in_2, d_in_3, d_in_4, out_ready,
    output in_ready, out_valid, d_out, out_idx, out_last
  );

  modport master (
    output in_valid, d_in_1, d_in_2, d_in_3, d_in_4, out_ready,
    input  in_ready, out_valid, d_out, out_idx, out_last
  );
endinterface

// File: rtl/idct4_row_engine.sv
// Streaming 4-point inverse-DCT row engine (HEVC basis 64/83/36).
// Latches one coefficient vector x0..x3 and emits y0..y3 serially, one per
// accepted output beat, with optional rounding shift and saturation.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : idct4_row_engine_if.slave (input vector handshake, output beat handshake)
module idct4_row_engine #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 24,
  parameter int SHIFT = 0,
  parameter int SAT   = 1
) (
  input logic                clk,
  input logic                reset,
  idct4_row_engine_if.slave  bus
);

  localparam int PW     = IN_W + 8;
  localparam int AW     = IN_W + 10;
  localparam int EW     = ((AW > OUT_W) ? AW : OUT_W) + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int RND    = (SHIFT > 0) ? (1 << RND_SH) : 0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // One basis column: full-precision MAC, round, then saturate or wrap.
  function automatic logic signed [OUT_W-1:0] col_result(
    input logic signed [IN_W-1:0] a,
    input logic signed [IN_W-1:0] b,
    input logic signed [IN_W-1:0] c,
    input logic signed [IN_W-1:0] e,
    input logic [1:0]             k
  );
    logic signed [7:0]    c1, c2, c3;
    logic signed [PW-1:0] p0, p1, p2, p3;
    logic signed [AW-1:0] acc, acc_r;
    logic signed [EW-1:0] ext, maxv, minv;
    logic signed [OUT_W-1:0] res;
    case (k)
      2'd0:    begin c1 = 8'sd83;  c2 = 8'sd64;  c3 = 8'sd36;  end
      2'd1:    begin c1 = 8'sd36;  c2 = -8'sd64; c3 = -8'sd83; end
      2'd2:    begin c1 = -8'sd36; c2 = -8'sd64; c3 = 8'sd83;  end
      default: begin c1 = -8'sd83; c2 = 8'sd64;  c3 = -8'sd36; end
    endcase
    p0    = PW'(a) * PW'(8'sd64);
    p1    = PW'(b) * PW'(c1);
    p2    = PW'(c) * PW'(c2);
    p3    = PW'(e) * PW'(c3);
    acc   = AW'(p0) + AW'(p1) + AW'(p2) + AW'(p3);
    acc_r = (acc + AW'(RND)) >>> SHIFT;
    ext   = EW'(acc_r);
    maxv  = (EW'(1) <<< (OUT_W - 1)) - EW'(1);
    minv  = -(EW'(1) <<< (OUT_W - 1));
    res   = OUT_W'(ext);
    if (SAT != 0) begin
      if (ext > maxv)      res = OUT_W'(maxv);
      else if (ext < minv) res = OUT_W'(minv);
    end
    return res;
  endfunction

  logic [0:0]              state_q, state_d;
  logic signed [IN_W-1:0]  x0_q, x0_d, x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
  logic signed [OUT_W-1:0] d_out_q, d_out_d;
  logic [1:0]              idx_q, idx_d;
  logic                    last_q, last_d;
  logic                    in_ready_c, xfer, consume;
  logic [1:0]              idx_nxt;

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    x3_d    = x3_q;
    d_out_d = d_out_q;
    idx_d   = idx_q;
    last_d  = last_q;
    idx_nxt = idx_q + 2'd1;

    in_ready_c = (state_q == ST_IDLE) || ((idx_q == 2'd3) && bus.out_ready);
    xfer       = bus.in_valid && in_ready_c;
    consume    = (state_q == ST_RUN) && bus.out_ready;

    if (xfer) begin
      // y0 comes straight from the incoming vector so a vector accepted
      // together with the final beat follows without a bubble.
      x0_d    = bus.d_in_1;
      x1_d    = bus.d_in_2;
      x2_d    = bus.d_in_3;
      x3_d    = bus.d_in_4;
      state_d = ST_RUN;
      idx_d   = 2'd0;
      last_d  = 1'b0;
      d_out_d = col_result(bus.d_in_1, bus.d_in_2, bus.d_in_3, bus.d_in_4, 2'd0);
    end else if (consume) begin
      if (idx_q == 2'd3) begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
        last_d  = 1'b0;
        d_out_d = '0;
      end else begin
        idx_d   = idx_nxt;
        last_d  = (idx_nxt == 2'd3);
        d_out_d = col_result(x0_q, x1_q, x2_q, x3_q, idx_nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      x3_q    <= '0;
      d_out_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      x3_q    <= x3_d;
      d_out_q <= d_out_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == ST_RUN);
  assign bus.d_out     = d_out_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_idct4_row_engine.sv
module tb_idct4_row_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  idct4_row_engine_if #(.IN_W(16), .OUT_W(24)) if0 ();
  idct4_row_engine_if #(.IN_W(16), .OUT_W(16)) if1 ();
  idct4_row_engine_if #(.IN_W(16), .OUT_W(16)) if2 ();
  idct4_row_engine_if #(.IN_W(16), .OUT_W(24)) if3 ();

  idct4_row_engine #(.IN_W(16), .OUT_W(24), .SHIFT(0), .SAT(1))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  idct4_row_engine #(.IN_W(16), .OUT_W(16), .SHIFT(0), .SAT(1))
    dut1 (.clk(clk), .reset(reset), .bus(if1));
  idct4_row_engine #(.IN_W(16), .OUT_W(16), .SHIFT(0), .SAT(0))
    dut2 (.clk(clk), .reset(reset), .bus(if2));
  idct4_row_engine #(.IN_W(16), .OUT_W(24), .SHIFT(7), .SAT(1))
    dut3 (.clk(clk), .reset(reset), .bus(if3));

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_vec0(input int a, input int b, input int c, input int d);
    if0.d_in_1 = 16'(a);
    if0.d_in_2 = 16'(b);
    if0.d_in_3 = 16'(c);
    if0.d_in_4 = 16'(d);
  endtask

  // Transfer one vector into dut0 with out_ready held high and check all beats.
  task automatic run_vec0(input string tag, input int a, input int b, input int c,
                          input int d, input int e0, input int e1, input int e2,
                          input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    set_vec0(a, b, c, d);
    if0.in_valid  = 1'b1;
    if0.out_ready = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), 32'(if0.out_valid), 1);
      chk($sformatf("%s_y%0d", tag, k), if0.d_out, e[k]);
      chk($sformatf("%s_idx%0d", tag, k), 32'(if0.out_idx), k);
      chk($sformatf("%s_last%0d", tag, k), 32'(if0.out_last), (k == 3) ? 1 : 0);
      @(negedge clk);
    end
    chk($sformatf("%s_valid_end", tag), 32'(if0.out_valid), 0);
    chk($sformatf("%s_last_end", tag), 32'(if0.out_last), 0);
  endtask

  initial begin
    int exp_a[4];
    int exp_b[4];
    int bp_ready[7];
    int ptr;
    int sat1[4];
    int sat0[4];
    int v3[3][4];
    int e3[3][4];

    if0.in_valid = 1'b0; if0.out_ready = 1'b1; set_vec0(0, 0, 0, 0);
    if1.in_valid = 1'b0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.out_ready = 1'b1;
    if3.in_valid = 1'b0; if3.out_ready = 1'b1;
    {if1.d_in_1, if1.d_in_2, if1.d_in_3, if1.d_in_4} = '0;
    {if2.d_in_1, if2.d_in_2, if2.d_in_3, if2.d_in_4} = '0;
    {if3.d_in_1, if3.d_in_2, if3.d_in_3, if3.d_in_4} = '0;

    // Reset for 3 cycles
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(if0.out_valid), 0);
    chk("rst_dout", if0.d_out, 0);
    chk("rst_idx", 32'(if0.out_idx), 0);
    chk("rst_last", 32'(if0.out_last), 0);
    chk("rst_in_ready", 32'(if0.in_ready), 1);
    reset = 1'b1;
    @(negedge clk);

    run_vec0("unit", 1, 0, 0, 0, 64, 64, 64, 64);
    run_vec0("ones", 1, 1, 1, 1, 247, -47, 47, 9);

    // Back-to-back: second vector presented early, accepted with beat 3
    exp_a = '{83, 36, -36, -83};
    exp_b = '{-72, 166, -166, 72};
    set_vec0(0, 1, 0, 0);
    if0.in_valid  = 1'b1;
    if0.out_ready = 1'b1;
    @(negedge clk);
    set_vec0(0, 0, 0, -2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b_a_y%0d", k), if0.d_out, exp_a[k]);
      chk($sformatf("b2b_a_idx%0d", k), 32'(if0.out_idx), k);
      chk($sformatf("b2b_a_in_ready%0d", k), 32'(if0.in_ready), (k == 3) ? 1 : 0);
      @(negedge clk);
    end
    if0.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b_b_valid%0d", k), 32'(if0.out_valid), 1);
      chk($sformatf("b2b_b_y%0d", k), if0.d_out, exp_b[k]);
      chk($sformatf("b2b_b_idx%0d", k), 32'(if0.out_idx), k);
      @(negedge clk);
    end
    chk("b2b_valid_end", 32'(if0.out_valid), 0);

    // Backpressure
    exp_a    = '{247, -47, 47, 9};
    bp_ready = '{1, 0, 0, 1, 0, 1, 1};
    set_vec0(1, 1, 1, 1);
    if0.in_valid  = 1'b1;
    if0.out_ready = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    ptr = 0;
    for (int i = 0; i < 7; i++) begin
      if0.out_ready = bp_ready[i][0];
      #1;
      chk($sformatf("bp_valid%0d", i), 32'(if0.out_valid), 1);
      chk($sformatf("bp_y%0d", i), if0.d_out, exp_a[ptr]);
      chk($sformatf("bp_idx%0d", i), 32'(if0.out_idx), ptr);
      chk($sformatf("bp_last%0d", i), 32'(if0.out_last), (ptr == 3) ? 1 : 0);
      chk($sformatf("bp_in_ready%0d", i), 32'(if0.in_ready),
          (ptr == 3 && bp_ready[i] == 1) ? 1 : 0);
      @(negedge clk);
      if (bp_ready[i] == 1) ptr++;
    end
    chk("bp_beats", ptr, 4);
    chk("bp_valid_end", 32'(if0.out_valid), 0);
    if0.out_ready = 1'b1;

    // Reset mid-vector
    set_vec0(1, 1, 1, 1);
    if0.in_valid = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    chk("mid_y0", if0.d_out, 247);
    @(negedge clk);
    chk("mid_y1", if0.d_out, -47);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(if0.out_valid), 0);
    chk("mid_rst_dout", if0.d_out, 0);
    chk("mid_rst_in_ready", 32'(if0.in_ready), 1);
    chk("mid_rst_idx", 32'(if0.out_idx), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_idle_valid", 32'(if0.out_valid), 0);
    run_vec0("post", 1, 0, 0, 0, 64, 64, 64, 64);

    // OUT_W=16 with SAT=1 (dut1) and SAT=0 (dut2)
    sat1 = '{32767, -32768, 32767, 32767};
    sat0 = '{32521, -32721, 32721, 32759};
    {if1.d_in_1, if1.d_in_2, if1.d_in_3, if1.d_in_4} = {4{16'sd32767}};
    {if2.d_in_1, if2.d_in_2, if2.d_in_3, if2.d_in_4} = {4{16'sd32767}};
    if1.in_valid = 1'b1;
    if2.in_valid = 1'b1;
    @(negedge clk);
    if1.in_valid = 1'b0;
    if2.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sat1_y%0d", k), if1.d_out, sat1[k]);
      chk($sformatf("sat1_idx%0d", k), 32'(if1.out_idx), k);
      chk($sformatf("sat0_y%0d", k), if2.d_out, sat0[k]);
      chk($sformatf("sat0_valid%0d", k), 32'(if2.out_valid), 1);
      @(negedge clk);
    end
    chk("sat1_valid_end", 32'(if1.out_valid), 0);

    // SHIFT=7 rounding (dut3)
    v3 = '{'{1, 0, 0, 0}, '{-1, 0, 0, 0}, '{0, 1, 0, 0}};
    e3 = '{'{1, 1, 1, 1}, '{0, 0, 0, 0}, '{1, 0, 0, -1}};
    for (int v = 0; v < 3; v++) begin
      if3.d_in_1   = 16'(v3[v][0]);
      if3.d_in_2   = 16'(v3[v][1]);
      if3.d_in_3   = 16'(v3[v][2]);
      if3.d_in_4   = 16'(v3[v][3]);
      if3.in_valid = 1'b1;
      @(negedge clk);
      if3.in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("sh7_v%0d_y%0d", v, k), if3.d_out, e3[v][k]);
        chk($sformatf("sh7_v%0d_valid%0d", v, k), 32'(if3.out_valid), 1);
        @(negedge clk);
      end
      chk($sformatf("sh7_v%0d_valid_end", v), 32'(if3.out_valid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
